// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with a transaction watchdog.
// The bus is always parked on exactly one owner. A registered
// watchdog tracks outstanding transactions and raises a one-cycle
// timeout_err pulse if the slave never answers.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction outstanding; arbitration is live
// WAIT  | strobe seen, waiting for m_rdy_n; owner frozen
// ERR   | watchdog expired this cycle; owner forced to rotate
module bus_arbiter_rr #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_n,
  input  logic       m1_req_n,
  input  logic       m2_req_n,
  input  logic       m3_req_n,
  input  logic       m_as_n,
  input  logic       m_rdy_n,
  output logic       m0_grnt_n,
  output logic       m1_grnt_n,
  output logic       m2_grnt_n,
  output logic       m3_grnt_n,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [1:0]           owner_nxt;
  logic [3:0]           req;
  logic                 rot_found;
  logic [1:0]           rot_pick;
  logic [1:0]           rot_cand;

  assign req = ~{m3_req_n, m2_req_n, m1_req_n, m0_req_n};

  // First requester after the current owner in rotation order (owner+1..owner+3).
  always_comb begin
    rot_found = 1'b0;
    rot_pick  = owner;
    rot_cand  = owner;
    for (int i = 1; i < 4; i++) begin
      rot_cand = owner + 2'(i);
      if (!rot_found && req[rot_cand]) begin
        rot_found = 1'b1;
        rot_pick  = rot_cand;
      end
    end
  end

  // Next owner: keep while requesting in IDLE, forced rotation in ERR, frozen in WAIT.
  always_comb begin
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (!req[owner] && rot_found) begin
          owner_nxt = rot_pick;
        end
      end
      ERR: begin
        if (rot_found) begin
          owner_nxt = rot_pick;
        end
      end
      default: begin
        owner_nxt = owner;
      end
    endcase
  end

  // Watchdog next-state and counter; ready wins over expiry in the last wait cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = CNT_ZERO;
        if (!m_as_n && m_rdy_n) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT: begin
        if (!m_rdy_n) begin
          state_nxt = IDLE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LIMIT) begin
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ERR: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and owner registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
      owner <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
    end
  end

  assign m0_grnt_n   = (owner != 2'd0);
  assign m1_grnt_n   = (owner != 2'd1);
  assign m2_grnt_n   = (owner != 2'd2);
  assign m3_grnt_n   = (owner != 2'd3);
  assign bus_busy    = (state == WAIT);
  assign timeout_err = (state == ERR);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios followed by random traffic,
// all compared each cycle against a behavioural model of the arbiter.
module tb_bus_arbiter_rr;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req_n, m1_req_n, m2_req_n, m3_req_n;
  logic       m_as_n, m_rdy_n;
  logic       m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n;
  logic [1:0] owner;
  logic       bus_busy, timeout_err;

  int checks = 0;
  int errors = 0;

  // Model: owner index, whether a transaction is outstanding, how many
  // cycles it has been waited on, and whether this cycle is the error cycle.
  int mdl_owner   = 0;
  bit mdl_waiting = 0;
  int mdl_waited  = 0;
  bit mdl_err     = 0;

  bus_arbiter_rr #(.TIMEOUT(TO), .CNT_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_req_n    (m0_req_n),
    .m1_req_n    (m1_req_n),
    .m2_req_n    (m2_req_n),
    .m3_req_n    (m3_req_n),
    .m_as_n      (m_as_n),
    .m_rdy_n     (m_rdy_n),
    .m0_grnt_n   (m0_grnt_n),
    .m1_grnt_n   (m1_grnt_n),
    .m2_grnt_n   (m2_grnt_n),
    .m3_grnt_n   (m3_grnt_n),
    .owner       (owner),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rotate_pick(input int cur, input bit [3:0] rq);
    for (int k = 1; k <= 3; k++) begin
      if (rq[(cur + k) % 4]) return (cur + k) % 4;
    end
    return cur;
  endfunction

  task automatic model_edge(input bit rst, input bit [3:0] rq_n, input bit as_n_i, input bit rdy_n_i);
    bit [3:0] rq;
    int nxt_owner;
    rq = ~rq_n;
    if (rst) begin
      mdl_owner   = 0;
      mdl_waiting = 0;
      mdl_waited  = 0;
      mdl_err     = 0;
      return;
    end
    nxt_owner = mdl_owner;
    if (mdl_err) nxt_owner = rotate_pick(mdl_owner, rq);
    else if (!mdl_waiting && !rq[mdl_owner]) nxt_owner = rotate_pick(mdl_owner, rq);
    if (mdl_err) begin
      mdl_err = 0;
    end else if (mdl_waiting) begin
      if (!rdy_n_i) begin
        mdl_waiting = 0;
        mdl_waited  = 0;
      end else if (mdl_waited >= TO) begin
        mdl_waiting = 0;
        mdl_waited  = 0;
        mdl_err     = 1;
      end else begin
        mdl_waited++;
      end
    end else if (!as_n_i && rdy_n_i) begin
      mdl_waiting = 1;
      mdl_waited  = 1;
    end
    mdl_owner = nxt_owner;
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs to the model.
  task automatic step(input bit rst, input bit [3:0] rq_n, input bit as_n_i, input bit rdy_n_i);
    logic [3:0] exp_g;
    reset    = rst;
    m0_req_n = rq_n[0];
    m1_req_n = rq_n[1];
    m2_req_n = rq_n[2];
    m3_req_n = rq_n[3];
    m_as_n   = as_n_i;
    m_rdy_n  = rdy_n_i;
    @(posedge clk);
    model_edge(rst, rq_n, as_n_i, rdy_n_i);
    #1;
    exp_g = ~(4'b0001 << mdl_owner);
    chk("owner", 8'(owner), 8'(mdl_owner));
    chk("grants", 8'({m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n}), 8'(exp_g));
    chk("bus_busy", 8'(bus_busy), 8'(mdl_waiting));
    chk("timeout_err", 8'(timeout_err), 8'(mdl_err));
  endtask

  initial begin
    bit [3:0] rq_n;
    bit       seen_err;

    reset = 1'b1; m0_req_n = 1'b1; m1_req_n = 1'b1; m2_req_n = 1'b1; m3_req_n = 1'b1;
    m_as_n = 1'b1; m_rdy_n = 1'b1;

    // Reset then idle: parked on master 0.
    step(1, 4'b1111, 1, 1);
    chk("rst_owner", 8'(owner), 8'd0);
    chk("rst_g0", 8'(m0_grnt_n), 8'd0);
    for (int i = 0; i < 5; i++) step(0, 4'b1111, 1, 1);
    chk("idle_owner", 8'(owner), 8'd0);
    chk("idle_busy", 8'(bus_busy), 8'd0);

    // Round-robin handover 0 -> 1 -> 2 -> 3.
    step(0, 4'b0001, 1, 1);
    chk("rr_1", 8'(owner), 8'd1);
    step(0, 4'b0001, 1, 1);
    chk("rr_hold1", 8'(owner), 8'd1);
    step(0, 4'b0011, 1, 1);
    chk("rr_2", 8'(owner), 8'd2);
    step(0, 4'b0111, 1, 1);
    chk("rr_3", 8'(owner), 8'd3);

    // Zero-wait access, then a 3-cycle wait with a release inside WAIT.
    step(1, 4'b1111, 1, 1);
    step(0, 4'b1100, 0, 0);
    chk("zw_busy", 8'(bus_busy), 8'd0);
    step(0, 4'b1100, 0, 1);
    chk("w_busy1", 8'(bus_busy), 8'd1);
    step(0, 4'b1101, 1, 1);
    chk("w_busy2", 8'(bus_busy), 8'd1);
    chk("w_frozen", 8'(owner), 8'd0);
    step(0, 4'b1101, 1, 1);
    chk("w_busy3", 8'(bus_busy), 8'd1);
    step(0, 4'b1101, 1, 0);
    chk("w_done", 8'(bus_busy), 8'd0);
    chk("w_owner_held", 8'(owner), 8'd0);
    step(0, 4'b1101, 1, 1);
    chk("w_handover", 8'(owner), 8'd1);

    // Timeout with owner 2 and master 3 waiting.
    step(1, 4'b1111, 1, 1);
    step(0, 4'b1011, 1, 1);
    chk("to_owner2", 8'(owner), 8'd2);
    step(0, 4'b0011, 0, 1);
    for (int c = 1; c <= 15; c++) step(0, 4'b0011, 1, 1);
    chk("to_busy16", 8'(bus_busy), 8'd1);
    step(0, 4'b0011, 1, 1);
    chk("to_err17", 8'(timeout_err), 8'd1);
    chk("to_owner17", 8'(owner), 8'd2);
    step(0, 4'b0011, 1, 1);
    chk("to_err18", 8'(timeout_err), 8'd0);
    chk("to_owner18", 8'(owner), 8'd3);

    // Boundary: ready arrives in the expiry cycle.
    step(1, 4'b1111, 1, 1);
    step(0, 4'b1011, 1, 1);
    step(0, 4'b0011, 0, 1);
    for (int c = 1; c <= 15; c++) step(0, 4'b0011, 1, 1);
    step(0, 4'b0011, 1, 0);
    chk("bd_err", 8'(timeout_err), 8'd0);
    chk("bd_busy", 8'(bus_busy), 8'd0);
    step(0, 4'b0011, 1, 1);
    chk("bd_owner", 8'(owner), 8'd2);

    // Reset in cycle 10 of a transaction headed for timeout.
    step(1, 4'b1111, 1, 1);
    step(0, 4'b1011, 1, 1);
    step(0, 4'b0011, 0, 1);
    for (int c = 1; c <= 9; c++) step(0, 4'b0011, 1, 1);
    step(1, 4'b0011, 1, 1);
    chk("rw_owner", 8'(owner), 8'd0);
    chk("rw_busy", 8'(bus_busy), 8'd0);
    seen_err = 0;
    for (int c = 0; c < 25; c++) begin
      step(0, 4'b1111, 1, 1);
      if (timeout_err) seen_err = 1;
    end
    chk("rw_no_err", 8'(seen_err), 8'd0);

    // Random traffic: normal ready rate, then a slow slave to provoke timeouts.
    for (int n = 0; n < 600; n++) begin
      rq_n = 4'($urandom);
      step(($urandom_range(0, 63) == 0), rq_n, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) == 0));
    end
    for (int n = 0; n < 1200; n++) begin
      rq_n = 4'($urandom);
      step(($urandom_range(0, 255) == 0), rq_n, ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 24) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of wait cycles allowed after an address strobe before a bus-timeout (legal range 2..255).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning the width of the watchdog counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports m0_req_n..m3_req_n  input  1 each  bus requests from masters 0-3, active-low.
REQ-006 SHALL have port m_as_n  input  1  address strobe of the current owner, active-low.
REQ-007 SHALL have port m_rdy_n  input  1  ready from the slave mux, active-low.
REQ-008 SHALL have ports m0_grnt_n..m3_grnt_n  output  1 each  bus grants, active-low.
REQ-009 SHALL have port owner  output  2  index of the master currently granted.
REQ-010 SHALL have port bus_busy  output  1  high while a transaction is outstanding.
REQ-011 SHALL have port timeout_err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-012 SHALL decode grants from the owner register, so exactly one grnt_n is low in every cycle (the bus is always parked on an owner).
REQ-013 SHALL use a registered watchdog FSM with states IDLE, WAIT and ERR.
REQ-014 IDLE: SHALL stay in IDLE if m_as_n is low and m_rdy_n is low in the same cycle (zero-wait access).
REQ-015 IDLE: SHALL go to WAIT with cnt=1 if m_as_n is low and m_rdy_n is high.
REQ-016 WAIT: SHALL go to IDLE with cnt=0 if m_rdy_n is low.
REQ-017 WAIT: SHALL go to ERR if m_rdy_n is high and cnt==TIMEOUT, otherwise increment cnt.
REQ-018 ERR: SHALL last exactly one cycle and then go to IDLE with cnt=0.
REQ-019 SHALL give m_rdy_n low priority over expiry: m_rdy_n low while cnt==TIMEOUT returns the FSM to IDLE with no error.
REQ-020 SHALL ignore m_as_n while in WAIT or ERR.
REQ-021 SHALL drive bus_busy high exactly when the state is WAIT (combinational from state).
REQ-022 SHALL drive timeout_err high exactly in the ERR cycle (combinational from state).
REQ-023 Arbitration SHALL be evaluated only in IDLE or ERR; the owner is frozen during WAIT regardless of req_n.
REQ-024 In IDLE, SHALL keep the current owner while its req_n is low (no preemption).
REQ-025 In IDLE, if the owner's req_n is high, the next owner SHALL be the first master with req_n low, searching owner+1, owner+2, owner+3 (mod 4).
REQ-026 In IDLE, if no master requests, the owner SHALL remain unchanged (park).
REQ-027 In ERR, the next owner SHALL be the first requester among owner+1..owner+3 (mod 4), ignoring the current owner's request; if there is none, the owner is unchanged.
REQ-028 Grant latency SHALL be one cycle: the owner register updates on the edge at which the arbitration decision is sampled.
REQ-029 Simultaneous requests SHALL be resolved solely by the rotation order in REQ-025, giving a worst-case wait of 3 tenures.
REQ-030 If an IDLE-state arbitration handover and m_as_n low occur in the same cycle, the FSM SHALL still update from m_as_n, and the strobe is attributed to the outgoing owner.

Reset
REQ-031 On reset high at a clock edge, SHALL set owner=0, state=IDLE and cnt=0, giving m0_grnt_n=0, m1..m3_grnt_n=1, bus_busy=0 and timeout_err=0 in the next cycle.
REQ-032 Reset SHALL override all other inputs, including mid-WAIT and in the ERR cycle.
REQ-033 After reset, no timeout_err SHALL be produced for a transaction begun before reset.

Verification
REQ-034 Reset then idle: no requests -> owner=0 and m0_grnt_n=0 held indefinitely; bus_busy=0.
REQ-035 Round-robin: owner=0, m0_req_n=1, m1..m3_req_n=0 held -> owner sequence 1 -> (m1 releases) 2 -> (m2 releases) 3, each change one cycle after release; no master skipped.
REQ-036 Zero-wait versus wait: m_as_n=0 with m_rdy_n=0 -> bus_busy stays 0; m_as_n=0 with m_rdy_n=0 three cycles later -> bus_busy=1 for 3 cycles; a release of req_n during WAIT leaves owner unchanged until WAIT exits.
REQ-037 Timeout: TIMEOUT=16, owner=2, m_as_n=0 at cycle 0, m_rdy_n held 1, m3_req_n=0 -> bus_busy=1 in cycles 1-16; timeout_err=1 in cycle 17 only; owner=3 from cycle 18.
REQ-038 Boundary: same setup with m_rdy_n=0 in cycle 16 -> no timeout_err; IDLE in cycle 17; owner=2 retained while m2_req_n=0.
REQ-039 Reset mid-WAIT: reset=1 in cycle 10 of a timeout-bound transaction -> owner=0, bus_busy=0 from cycle 11; timeout_err never asserts.
